ro_slot_mux: RTL and testbench



---
 rtl/ro_slot_mux_if.sv | 28 ++
 rtl/ro_slot_mux.sv | 99 +++++++++
 tb/tb_ro_slot_mux.sv | 195 +++++++++++++++++++
 3 files changed

// File: rtl/ro_slot_mux_if.sv
// Bus bundle for the readout slot multiplexer: slot control and core data in,
// serviced-core readout and gray slot count out.
interface ro_slot_mux_if #(
    parameter int N_CORES = 4,
    parameter int N_BITS  = 2,
    parameter int CNT_W   = 19,
    parameter int CORE_W  = (N_CORES > 1) ? $clog2(N_CORES) : 1
);
    // readout_valid is a one-cycle strobe with no back-pressure: readout and
    // readout_core are meaningful only in the cycle it is high.
    logic                        en;
    logic [N_CORES-1:0]          core_en;
    logic [N_CORES*N_BITS-1:0]   in_data;
    logic [N_BITS-1:0]           readout;
    logic                        readout_valid;
    logic [CORE_W-1:0]           readout_core;
    logic [CNT_W-1:0]            gray_count;

    modport master (
        output en, core_en, in_data,
        input  readout, readout_valid, readout_core, gray_count
    );

    modport slave (
        input  en, core_en, in_data,
        output readout, readout_valid, readout_core, gray_count
    );
endinterface

// File: rtl/ro_slot_mux.sv
// Readout slot multiplexer: a binary slot counter grants core k a slot whenever
// gray bit k toggles, so core k is read every 2^(k+1) enabled cycles.
module ro_slot_mux #(
    parameter int N_CORES = 4,
    parameter int N_BITS  = 2,
    parameter int CNT_W   = 19,
    parameter int STICKY  = 1
) (
    input  logic          clk_master,
    input  logic          rstb,
    ro_slot_mux_if.slave  bus
);
    localparam int CORE_W = (N_CORES > 1) ? $clog2(N_CORES) : 1;

    logic [CNT_W-1:0]                 cnt_q, cnt_d;
    logic [CNT_W-1:0]                 gray_q, gray_d;
    logic [N_BITS-1:0]                readout_q, readout_d;
    logic                             valid_q, valid_d;
    logic [CORE_W-1:0]                core_q, core_d;
    logic [N_CORES-1:0][N_BITS-1:0]   hold_q;
    logic [N_CORES-1:0]               slot_sel;
    int                               slot_k;

    // Slot index is the position of the lowest zero of the counter, i.e. the
    // gray bit that toggles on the next increment; all-ones maps to the MSB.
    always_comb begin
        slot_k   = CNT_W - 1;
        slot_sel = '0;
        for (int i = CNT_W - 1; i >= 0; i--) begin
            if (!cnt_q[i]) slot_k = i;
        end
        for (int j = 0; j < N_CORES; j++) begin
            slot_sel[j] = bus.en && (slot_k == j);
        end
    end

    always_comb begin
        cnt_d     = cnt_q;
        gray_d    = gray_q;
        valid_d   = 1'b0;
        readout_d = '0;
        core_d    = core_q;
        if (bus.en) begin
            cnt_d  = cnt_q + 1'b1;
            gray_d = cnt_d ^ (cnt_d >> 1);
        end
        for (int j = 0; j < N_CORES; j++) begin
            if (slot_sel[j] && bus.core_en[j]) begin
                valid_d   = 1'b1;
                core_d    = CORE_W'(j);
                readout_d = hold_q[j] | bus.in_data[j*N_BITS +: N_BITS];
            end
        end
    end

    generate
        if (STICKY != 0) begin : g_hold
            logic [N_CORES-1:0][N_BITS-1:0] hold_d;

            // The slot core's pending bits are consumed (or dropped when the
            // core is masked); every other core keeps OR-accumulating.
            always_comb begin
                hold_d = '0;
                for (int j = 0; j < N_CORES; j++) begin
                    hold_d[j] = slot_sel[j] ? '0
                              : (hold_q[j] | bus.in_data[j*N_BITS +: N_BITS]);
                end
            end

            always_ff @(posedge clk_master) begin
                if (!rstb) hold_q <= '0;
                else       hold_q <= hold_d;
            end
        end else begin : g_no_hold
            assign hold_q = '0;
        end
    endgenerate

    always_ff @(posedge clk_master) begin
        if (!rstb) begin
            cnt_q     <= '0;
            gray_q    <= '0;
            readout_q <= '0;
            valid_q   <= 1'b0;
            core_q    <= '0;
        end else begin
            cnt_q     <= cnt_d;
            gray_q    <= gray_d;
            readout_q <= readout_d;
            valid_q   <= valid_d;
            core_q    <= core_d;
        end
    end

    assign bus.readout       = readout_q;
    assign bus.readout_valid = valid_q;
    assign bus.readout_core  = core_q;
    assign bus.gray_count    = gray_q;
endmodule

// File: tb/tb_ro_slot_mux.sv
// Bench for ro_slot_mux: sticky and non-sticky instances share stimulus and
// are checked against per-cycle expectations queued by the driver.
module tb_ro_slot_mux;
    localparam int N_CORES = 4;
    localparam int N_BITS  = 2;
    localparam int CNT_W   = 6;

    logic clk;
    logic rstb;
    int   total = 0;
    int   bad   = 0;

    ro_slot_mux_if #(.N_CORES(N_CORES), .N_BITS(N_BITS), .CNT_W(CNT_W)) bus0 ();
    ro_slot_mux_if #(.N_CORES(N_CORES), .N_BITS(N_BITS), .CNT_W(CNT_W)) bus1 ();

    ro_slot_mux #(.N_CORES(N_CORES), .N_BITS(N_BITS), .CNT_W(CNT_W), .STICKY(1)) dut_s (
        .clk_master (clk),
        .rstb       (rstb),
        .bus        (bus0)
    );

    ro_slot_mux #(.N_CORES(N_CORES), .N_BITS(N_BITS), .CNT_W(CNT_W), .STICKY(0)) dut_n (
        .clk_master (clk),
        .rstb       (rstb),
        .bus        (bus1)
    );

    // clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // per-cycle entry {gray, valid, core}; per-strobe entry {data}
    logic [8:0] exp_q0[$];
    logic [8:0] exp_q1[$];
    logic [1:0] exp_d0[$];
    logic [1:0] exp_d1[$];

    logic [5:0] mc;
    logic [1:0] pend [4];
    logic [1:0] last_core;

    function automatic logic [5:0] g(input logic [5:0] x);
        return x ^ (x >> 1);
    endfunction

    task automatic chk(input string name, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s actual=%0d required=%0d at %0t", name, act, exp, $time);
        end
    endtask

    // driver: apply one cycle of inputs, then queue what the outputs must show
    task automatic step(input logic r, input logic e, input logic [3:0] ce, input logic [7:0] d);
        logic [5:0] diff;
        int         kk;
        logic       v;
        logic [1:0] dat_s, dat_n, inj;
        rstb = r;
        bus0.en = e; bus0.core_en = ce; bus0.in_data = d;
        bus1.en = e; bus1.core_en = ce; bus1.in_data = d;
        @(posedge clk);
        #1;
        v = 1'b0; dat_s = 2'b00; dat_n = 2'b00;
        if (!r) begin
            mc = '0;
            last_core = '0;
            for (int j = 0; j < 4; j++) pend[j] = 2'b00;
        end else if (e) begin
            diff = g(mc) ^ g(mc + 6'd1);
            kk = 0;
            for (int i = 0; i < 6; i++) if (diff[i]) kk = i;
            for (int j = 0; j < 4; j++) begin
                inj = d[j*2 +: 2];
                if (kk == j) begin
                    if (ce[j]) begin
                        v = 1'b1;
                        dat_s = pend[j] | inj;
                        dat_n = inj;
                        last_core = 2'(j);
                    end
                    pend[j] = 2'b00;
                end else begin
                    pend[j] = pend[j] | inj;
                end
            end
            mc = mc + 6'd1;
        end else begin
            for (int j = 0; j < 4; j++) pend[j] = pend[j] | d[j*2 +: 2];
        end
        exp_q0.push_back({g(mc), v, last_core});
        exp_q1.push_back({g(mc), v, last_core});
        if (v) begin
            exp_d0.push_back(dat_s);
            exp_d1.push_back(dat_n);
        end
    endtask

    task automatic run_to(input logic [5:0] t, input logic [3:0] ce, input logic [7:0] d);
        for (int n = 0; n < 100 && mc != t; n++) step(1'b1, 1'b1, ce, d);
        chk("run_to_bound", int'(mc), int'(t));
    endtask

    // scoreboard monitor, shared by both instances
    task automatic mon(input int idx, input logic [5:0] gr, input logic v,
                       input logic [1:0] core, input logic [1:0] ro);
        logic [8:0] e;
        logic [1:0] ed;
        string      tag;
        tag = (idx == 0) ? "sticky" : "plain";
        if (idx == 0) begin
            if (exp_q0.size() == 0) return;
            e = exp_q0.pop_front();
        end else begin
            if (exp_q1.size() == 0) return;
            e = exp_q1.pop_front();
        end
        chk({tag, "_gray"},  int'(gr),   int'(e[8:3]));
        chk({tag, "_valid"}, int'(v),    int'(e[2]));
        chk({tag, "_core"},  int'(core), int'(e[1:0]));
        if (!v) begin
            chk({tag, "_idle_readout"}, int'(ro), 0);
        end else begin
            if (idx == 0 && exp_d0.size() > 0) ed = exp_d0.pop_front();
            else if (idx == 1 && exp_d1.size() > 0) ed = exp_d1.pop_front();
            else ed = 2'bxx;
            chk({tag, "_readout"}, int'(ro), int'(ed));
        end
    endtask

    always @(negedge clk) begin
        mon(0, bus0.gray_count, bus0.readout_valid, bus0.readout_core, bus0.readout);
        mon(1, bus1.gray_count, bus1.readout_valid, bus1.readout_core, bus1.readout);
    end

    initial begin
        mc = '0;
        last_core = '0;
        for (int j = 0; j < 4; j++) pend[j] = 2'b00;
        rstb = 1'b0;
        bus0.en = 1'b0; bus0.core_en = '0; bus0.in_data = '0;
        bus1.en = 1'b0; bus1.core_en = '0; bus1.in_data = '0;

        // reset wins over en with all inputs high, then one full counter period
        repeat (3) step(1'b0, 1'b1, 4'hF, 8'hFF);
        repeat (64) step(1'b1, 1'b1, 4'hF, 8'hFF);

        // one-cycle pulse on core 3 at c=1: reported at c=7 (sticky), then clean
        step(1'b0, 1'b0, 4'hF, 8'h00);
        run_to(6'd1, 4'hF, 8'h00);
        step(1'b1, 1'b1, 4'hF, 8'h40);
        run_to(6'd24, 4'hF, 8'h00);

        // core 2 masked: its slots idle and its earlier pulse is dropped
        step(1'b0, 1'b0, 4'hB, 8'h00);
        run_to(6'd1, 4'hB, 8'h00);
        step(1'b1, 1'b1, 4'hB, 8'h30);
        run_to(6'd12, 4'hB, 8'h00);
        run_to(6'd24, 4'hB, 8'hFF);

        // freeze at c=9 with a core 1 pulse, then resume into the core 1 slot
        step(1'b0, 1'b0, 4'hF, 8'h00);
        run_to(6'd9, 4'hF, 8'h00);
        repeat (4) step(1'b1, 1'b0, 4'hF, 8'h00);
        step(1'b1, 1'b0, 4'hF, 8'h08);
        repeat (5) step(1'b1, 1'b0, 4'hF, 8'h00);
        repeat (3) step(1'b1, 1'b1, 4'hF, 8'h00);

        // reset at c=20 with pending data on all cores clears it
        step(1'b0, 1'b0, 4'hF, 8'h00);
        run_to(6'd17, 4'hF, 8'h00);
        repeat (2) step(1'b1, 1'b1, 4'hF, 8'hFF);
        step(1'b1, 1'b0, 4'hF, 8'hFF);
        run_to(6'd20, 4'hF, 8'h00);
        step(1'b0, 1'b1, 4'hF, 8'h00);
        repeat (8) step(1'b1, 1'b1, 4'hF, 8'h00);

        // a few cycles of random masks and data on a free-running counter
        for (int n = 0; n < 40; n++) begin
            step(1'b1, 1'($urandom_range(0, 3) != 0), 4'($urandom_range(0, 15)),
                 8'($urandom_range(0, 255)));
        end

        step(1'b1, 1'b0, 4'hF, 8'h00);
        @(posedge clk);
        @(posedge clk);
        chk("leftover_cycles_sticky", exp_q0.size(), 0);
        chk("leftover_cycles_plain",  exp_q1.size(), 0);
        chk("leftover_data_sticky",   exp_d0.size(), 0);
        chk("leftover_data_plain",    exp_d1.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
